bin_bcd_scan: RTL and testbench
===============================

BIN_BCD_SCAN -- requirements
Module: bin_bcd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: CLK cycles per digit slot; legal range is 2 or more.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port LOAD, input, 1 bit: start a conversion of BIN; sampled at the rising edge.
REQ-007 SHALL have port BIN, input, 14 bits: unsigned binary value to display.
REQ-008 SHALL have port BUSY, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port OVF, output, 1 bit: high when the last accepted BIN was greater than 9999.
REQ-010 SHALL have port CE, output, 1 bit: one-cycle digit strobe; drives the downstream segment decoder's CE.
REQ-011 SHALL have port BCD, output, 4 bits: digit code for the downstream decoder; 4'hF means blank.
REQ-012 SHALL have port AN, output, 4 bits: active-low digit anodes; AN[0] is the least-significant digit.

Function
REQ-013 SHALL run a conversion FSM with states IDLE, SHIFT and COMMIT.
REQ-014 IDLE with LOAD=1 SHALL capture BIN, clear the iteration counter, go to SHIFT and set BUSY=1 at the same edge.
REQ-015 SHIFT SHALL perform one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift the 16-bit BCD and 14-bit binary registers left by 1; exactly 14 iterations.
REQ-016 After the 14th iteration the FSM SHALL go to COMMIT; in COMMIT it SHALL write 4 digits to the display register, set OVF = (captured BIN > 9999), return to IDLE and clear BUSY.
REQ-017 Latency SHALL be: LOAD accepted at edge k gives display register and OVF updated at edge k+15, with BUSY=1 from edge k through edge k+15.
REQ-018 LOAD while BUSY=1 SHALL be ignored, including in the COMMIT cycle; LOAD in the first cycle with BUSY=0 SHALL be accepted.
REQ-019 The display register SHALL hold its previous value for the whole conversion, so no partial result is ever shown.
REQ-020 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; CE=1 for exactly the one cycle in which the count equals SCAN_DIV-1.
REQ-021 The 2-bit digit index idx SHALL advance (idx+1) mod 4 at each edge where CE=1; at the same edge AN SHALL become active-low one-hot of the new idx.
REQ-022 BCD SHALL be registered and always present the code of digit (idx+1) mod 4; the decoder therefore latches that digit at the CE edge, and SEG and AN change together.
REQ-023 With OVF=1, every digit code SHALL be 4'hF.
REQ-024 With BLANK_LZ=1, digit n (n=3..1) SHALL be 4'hF when it and all higher digits are zero; digit 0 SHALL never be blanked.
REQ-025 A display-register update coinciding with a CE edge SHALL affect BCD from the following BCD update; no glitch or mixed-digit value is allowed.
REQ-026 BIN values 10000..16383 SHALL still convert without error; their result is discarded and only OVF is set.

Reset
REQ-027 RST_N=0 SHALL asynchronously set: FSM=IDLE, BUSY=0, OVF=0, display register=0000, prescaler=0, idx=0, CE=0, AN=4'b1111, BCD=4'hF.
REQ-028 Reset during SHIFT SHALL abort the conversion; after release the display shows 0.
REQ-029 After RST_N rises, the first CE SHALL occur SCAN_DIV cycles later, and LOAD SHALL be accepted on the first edge.

Verification
REQ-030 With SCAN_DIV=4, LOAD with BIN=1234 -> BUSY high for 16 edges; scan yields (AN,BCD-latched) pairs (1110,4), (1101,3), (1011,2), (0111,1), repeating every 16 cycles.
REQ-031 With BLANK_LZ=1, BIN=7 -> digits 3..1 blank (4'hF), digit 0=7; with BLANK_LZ=0 -> 0,0,0,7.
REQ-032 BIN=10000 -> OVF=1 and all four digits 4'hF; a following BIN=9999 -> OVF=0 and digits 9,9,9,9.
REQ-033 LOAD with BIN=42, then LOAD with BIN=55 at edges k+5 and k+15 -> second request ignored; display shows 42; LOAD at edge k+16 is accepted.
REQ-034 RST_N low at edge k+7 of a conversion of 8888 -> all outputs at reset values immediately, asynchronously; after release the display shows 0 and the first CE comes after SCAN_DIV cycles.

Source files
------------

// File: rtl/bin_bcd_scan.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// multiplexed display scanner with leading-zero blanking and overflow blanking.
module bin_bcd_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [13:0] BIN,
  output logic        BUSY,
  output logic        OVF,
  output logic        CE,
  output logic [3:0]  BCD,
  output logic [3:0]  AN
);

  localparam int unsigned    PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state, state_nx;
  logic [13:0] bin_sr;
  logic [15:0] bcd_sr;
  logic [15:0] bcd_adj;
  logic [3:0]  iter;
  logic        ovf_pend;
  logic [15:0] disp;
  logic [PW-1:0] pre;
  logic [1:0]  idx;
  logic [1:0]  idx_nx;
  logic [1:0]  sel;
  logic [3:0]  code [4];
  logic        zero_hi;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (LOAD) state_nx = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Overflowed results are dropped; the display keeps its last legal value
  // and OVF alone forces every digit blank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      OVF      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (LOAD) begin
          bin_sr   <= BIN;
          bcd_sr   <= '0;
          iter     <= '0;
          ovf_pend <= (BIN > 14'd9999);
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
          iter             <= iter + 4'd1;
        end
        COMMIT: begin
          OVF <= ovf_pend;
          if (!ovf_pend) disp <= bcd_sr;
        end
        default: ;
      endcase
    end
  end

  assign CE     = (pre == PRE_MAX);
  assign idx_nx = CE ? idx + 2'd1 : idx;
  assign sel    = idx_nx + 2'd1;

  always_comb begin
    zero_hi = 1'b1;
    for (int unsigned n = 0; n < 4; n++) code[n] = disp[4*n +: 4];
    for (int unsigned i = 0; i < 3; i++) begin
      zero_hi = zero_hi && (disp[4*(3-i) +: 4] == 4'd0);
      if (BLANK_LZ && zero_hi) code[3-i] = 4'hF;
    end
    if (OVF) begin
      for (int unsigned n = 0; n < 4; n++) code[n] = 4'hF;
    end
  end

  // BCD always runs one digit ahead of AN so the decoder latches the digit
  // that AN selects at the same CE edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre <= '0;
      idx <= '0;
      AN  <= '1;
      BCD <= '1;
    end else begin
      pre <= CE ? '0 : pre + PW'(1);
      BCD <= code[sel];
      if (CE) begin
        idx <= idx_nx;
        AN  <= ~(4'b0001 << idx_nx);
      end
    end
  end

endmodule

// File: tb/tb_bin_bcd_scan.sv
// Self-checking bench for bin_bcd_scan: randomized loads checked against a
// decimal-arithmetic model of the display and scan sequence.
module tb_bin_bcd_scan;

  localparam int SD = 4;

  logic        CLK;
  logic        RST_N;
  logic        LOAD;
  logic [13:0] BIN;
  logic        BUSY, OVF, CE;
  logic [3:0]  BCD, AN;
  logic        busy_b, ovf_b, ce_b;
  logic [3:0]  bcd_b, an_b;

  int checks   = 0;
  int failures = 0;

  // model state
  int   m_val, m_val_d, m_pend, m_left, m_pre, m_idx;
  bit   m_ovf, m_ovf_d;
  // values captured in the cycle before the most recent edge
  bit   e_ce, e_ovf_lat;
  int   e_val_lat;
  logic [3:0] pre_bcd1, pre_bcd0;

  bin_bcd_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .BIN(BIN),
    .BUSY(BUSY), .OVF(OVF), .CE(CE), .BCD(BCD), .AN(AN)
  );

  bin_bcd_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .BIN(BIN),
    .BUSY(busy_b), .OVF(ovf_b), .CE(ce_b), .BCD(bcd_b), .AN(an_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] exp_code(int val, bit ovf, bit blank, int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    if (ovf) return 4'hF;
    if (blank && n > 0 && val < p) return 4'hF;
    return 4'((val / p) % 10);
  endfunction

  task automatic reset_model();
    m_val = 0; m_val_d = 0; m_ovf = 0; m_ovf_d = 0;
    m_left = 0; m_pend = 0; m_pre = 0; m_idx = 0;
  endtask

  // One clock edge plus the model's view of what that edge does.
  task automatic tick();
    bit acc;
    int ld_v;
    pre_bcd1  = BCD;
    pre_bcd0  = bcd_b;
    e_ce      = (m_pre == SD - 1);
    e_val_lat = m_val_d;
    e_ovf_lat = m_ovf_d;
    m_val_d   = m_val;
    m_ovf_d   = m_ovf;
    acc       = LOAD && (m_left == 0);
    ld_v      = int'(BIN);
    @(posedge CLK);
    #1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_pend > 9999) m_ovf = 1;
        else begin m_val = m_pend; m_ovf = 0; end
      end
    end
    if (acc) begin m_left = 15; m_pend = ld_v; end
    if (e_ce) m_idx = (m_idx + 1) % 4;
    m_pre = (m_pre + 1) % SD;
  endtask

  task automatic do_load(int v);
    LOAD = 1'b1;
    BIN  = 14'(v);
    tick();
    LOAD = 1'b0;
  endtask

  task automatic test_scan(int n);
    logic [3:0] ea, e1, e0;
    for (int c = 0; c < n; c++) begin
      tick();
      checks++;
      if (BUSY !== (m_left > 0)) begin
        failures++; $display("FAIL busy: got %b expected %b", BUSY, m_left > 0);
      end
      checks++;
      if (OVF !== m_ovf) begin
        failures++; $display("FAIL ovf: got %b expected %b", OVF, m_ovf);
      end
      checks++;
      if (CE !== (m_pre == SD - 1) || ce_b !== CE) begin
        failures++; $display("FAIL ce: got %b/%b expected %b", CE, ce_b, m_pre == SD - 1);
      end
      if (e_ce) begin
        ea = ~(4'b0001 << m_idx);
        e1 = exp_code(e_val_lat, e_ovf_lat, 1'b1, m_idx);
        e0 = exp_code(e_val_lat, e_ovf_lat, 1'b0, m_idx);
        checks++;
        if (AN !== ea || an_b !== ea) begin
          failures++; $display("FAIL an: got %b/%b expected %b", AN, an_b, ea);
        end
        checks++;
        if (pre_bcd1 !== e1) begin
          failures++; $display("FAIL digit_blank: digit %0d got %h expected %h", m_idx, pre_bcd1, e1);
        end
        checks++;
        if (pre_bcd0 !== e0) begin
          failures++; $display("FAIL digit_noblank: digit %0d got %h expected %h", m_idx, pre_bcd0, e0);
        end
      end
    end
  endtask

  task automatic test_reset();
    int j;
    RST_N = 1'b0; LOAD = 1'b0; BIN = '0;
    reset_model();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0 || OVF !== 1'b0 || CE !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got busy=%b ovf=%b ce=%b expected 0 0 0", BUSY, OVF, CE);
    end
    checks++;
    if (AN !== 4'b1111 || an_b !== 4'b1111) begin
      failures++; $display("FAIL reset_an: got %b/%b expected 1111", AN, an_b);
    end
    checks++;
    if (BCD !== 4'hF || bcd_b !== 4'hF) begin
      failures++; $display("FAIL reset_bcd: got %h/%h expected f", BCD, bcd_b);
    end
    RST_N = 1'b1;
    reset_model();
    do_load(5);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++; $display("FAIL load_first_edge: got busy=%b expected 1", BUSY);
    end
    j = 1;
    while (CE !== 1'b1 && j < 4 * SD) begin tick(); j++; end
    checks++;
    if (j != SD - 1) begin
      failures++; $display("FAIL first_ce: got cycle %0d expected %0d", j, SD - 1);
    end
    test_scan(30);
  endtask

  task automatic test_conv_1234();
    do_load(1234);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++; $display("FAIL busy_start: got %b expected 1", BUSY);
    end
    test_scan(15);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++; $display("FAIL busy_end: got %b expected 0", BUSY);
    end
    test_scan(48);
  endtask

  task automatic test_blank();
    int v;
    do_load(7);
    test_scan(40);
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 9));
        1: v = int'($urandom_range(10, 999));
        2: v = int'($urandom_range(1000, 9999));
        default: v = int'($urandom_range(10000, 16383));
      endcase
      do_load(v);
      test_scan(15 + 4 * SD + int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_ovf();
    do_load(10000);
    test_scan(15);
    checks++;
    if (OVF !== 1'b1) begin
      failures++; $display("FAIL ovf_10000: got %b expected 1", OVF);
    end
    test_scan(20);
    do_load(9999);
    test_scan(15);
    checks++;
    if (OVF !== 1'b0) begin
      failures++; $display("FAIL ovf_9999: got %b expected 0", OVF);
    end
    test_scan(20);
    do_load(16383);
    test_scan(20);
  endtask

  task automatic test_back_to_back();
    do_load(42);
    test_scan(4);
    do_load(55);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++; $display("FAIL busy_mid: got %b expected 1", BUSY);
    end
    test_scan(9);
    do_load(55);
    checks++;
    if (BUSY !== 1'b0) begin
      failures++; $display("FAIL load_in_commit: got busy=%b expected 0", BUSY);
    end
    test_scan(2 * SD);
    do_load(55);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++; $display("FAIL load_after_commit: got busy=%b expected 1", BUSY);
    end
    test_scan(31);
  endtask

  task automatic test_reset_mid();
    int j;
    do_load(10500);
    test_scan(20);
    do_load(8888);
    test_scan(6);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || OVF !== 1'b0 || CE !== 1'b0) begin
      failures++; $display("FAIL async_reset_flags: got busy=%b ovf=%b ce=%b expected 0 0 0", BUSY, OVF, CE);
    end
    checks++;
    if (AN !== 4'b1111 || BCD !== 4'hF || bcd_b !== 4'hF) begin
      failures++; $display("FAIL async_reset_scan: got an=%b bcd=%h/%h expected 1111 f/f", AN, BCD, bcd_b);
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    reset_model();
    j = 0;
    while (CE !== 1'b1 && j < 4 * SD) begin tick(); j++; end
    checks++;
    if (j != SD - 1) begin
      failures++; $display("FAIL ce_after_reset: got cycle %0d expected %0d", j, SD - 1);
    end
    test_scan(40);
  endtask

  initial begin
    test_reset();
    test_conv_1234();
    test_blank();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
